sr_trace_monitor: RTL and testbench
===================================

Name: sr_trace_monitor

Overview:
- Synthesizable execution-trace and watchdog block for the schoolRISCV CPU, replacing the cycle print and fixed timeout of the simulation bench.
- Captures {cycle, pc, instr} every enabled CPU cycle into a circular buffer of DEPTH entries.
- Provides a programmable-timeout watchdog and a registered read-back port for the debug/board display path.
- Sits beside sm_cpu inside sm_top, sampling pc/instr on the divided-clock enable.

Parameters:
- DEPTH, 16: trace entries; power of two, 2..256.
- CYCLE_W, 16: cycle-counter width; saturates at all-ones.
- TIMEOUT, 120: enabled cycles before watchdog fires; 0 disables the watchdog.
- STALL_CYCLES, 8: consecutive cycles with the same pc that flag a halt (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; one CPU step per high cycle
- clr  in  1  synchronous clear of pointers, counter and flags
- pc  in  32  current CPU pc
- instr  in  32  current CPU instruction
- rdIdx  in  log2(DEPTH)  read index; 0 = oldest valid entry
- rdEn  in  1  read request
- rdValid  out  1  read data valid
- rdCycle  out  CYCLE_W  captured cycle number
- rdPc  out  32  captured pc
- rdInstr  out  32  captured instr
- count  out  log2(DEPTH)+1  valid entries, saturating at DEPTH
- wrapped  out  1  sticky; at least one entry has been overwritten
- timeout  out  1  sticky watchdog flag
- frozen  out  1  capture stopped
- halt  out  1  stall-detected flag (tied 0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0): wrPtr=0, cycle=0, count=0, wrapped=0, timeout=0, frozen=0, halt=0, rdValid=0, rdCycle/rdPc/rdInstr=0. Buffer RAM is not reset.
- Capture: on a clk edge with en=1, clr=0, frozen=0:
  - mem[wrPtr] <= {cycle, pc, instr}; wrPtr <= wrPtr+1 (wraps mod DEPTH).
  - cycle <= cycle+1, saturating at 2^CYCLE_W-1.
  - count <= min(count+1, DEPTH).
  - If count==DEPTH before the write, wrapped <= 1.
- Idle cycles: en=0 writes nothing and holds the counter; idle cycles are not counted.
- Watchdog (TIMEOUT != 0): when a capture makes cycle+1 == TIMEOUT, timeout and frozen set at that same edge.
  - Exactly TIMEOUT entries are captured, numbered 0..TIMEOUT-1.
  - Later en pulses are ignored until clr or reset.
- Read path, 1-cycle latency: a rdEn=1 sample at edge N produces registered outputs valid after edge N.
  - Physical address = (wrPtr - count + rdIdx) mod DEPTH.
  - If rdIdx < count: rdValid=1 with entry data.
  - Otherwise: rdValid=0 and data outputs 0.
  - rdEn=0 gives rdValid=0 and holds the data outputs.
  - Reads use the pointer/count values from before any same-cycle capture, so they are never affected by a write on the same edge.
- clr=1: wrPtr, cycle, count, wrapped, timeout, frozen, halt and stall counter go to 0 at the next edge. clr has priority over a simultaneous en capture; no write occurs that cycle.
- frozen also blocks the stall counter.
- Reset mid-capture: all state is lost immediately. No partial write is defined, and the entry is treated as not written.

Optional Feature:
- Macro: SR_TRACE_STALL_DETECT_EN.
- Defined:
  - A stall counter increments on each capture whose pc equals the previous captured pc; a capture with a different pc zeroes it.
  - When the counter reaches STALL_CYCLES-1 and the current capture repeats the pc, halt and frozen set at that edge.
  - This detects the terminal "beq x0,x0,0" loop.
- Undefined: no stall logic; halt is tied to 0.

Test Plan:
- Reset, then 5 captures with pc=0,4,8,12,16 → count=5, wrapped=0; rdIdx=0,rdEn=1 → next cycle rdValid=1, rdPc=0, rdCycle=0; rdIdx=5 → rdValid=0, data 0.
- DEPTH=16, 20 captures with pc=4*k → count=16, wrapped=1; rdIdx=0 gives rdPc=16, rdCycle=4; rdIdx=15 gives rdPc=76.
- TIMEOUT=120, en held high 200 cycles → timeout=frozen=1 after the 120th capture; the last entry (rdIdx=15) has rdCycle=119; count stays 16.
- Assert clr and en together at cycle 50 → no write that cycle; next edge count=0, cycle=0, flags 0; the next capture has rdCycle=0.
- en toggled 1,0,0,1 with pc=0,4 → count=2, rdCycle values 0 and 1; idle cycles are not counted.
- With SR_TRACE_STALL_DETECT_EN and STALL_CYCLES=8: pc=0x20 repeated 8 captures → halt=frozen=1 after the 8th; pc alternating 0x20/0x24 for 100 captures → halt stays 0.

Source files
------------

// File: rtl/sr_trace_if.sv
// sr_trace_if -- signal bundle between the schoolRISCV core side and the
// trace/watchdog monitor.
//
// Handshake: the read port is a request/response pair. The requester holds
// rdIdx and raises rdEn for one cycle. The monitor answers on the following
// cycle with rdValid plus rdCycle/rdPc/rdInstr. rdValid=0 alongside rdEn means
// that the index was beyond the valid entries. There is no back-pressure.
//
// Signals (master = core/bench side, slave = monitor):
//   en, clr, pc, instr, rdIdx, rdEn          master -> slave
//   rdValid, rdCycle, rdPc, rdInstr, count,
//   wrapped, timeout, frozen, halt           slave  -> master
interface sr_trace_if #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               en;
  logic               clr;
  logic [31:0]        pc;
  logic [31:0]        instr;
  logic [AW-1:0]      rdIdx;
  logic               rdEn;
  logic               rdValid;
  logic [CYCLE_W-1:0] rdCycle;
  logic [31:0]        rdPc;
  logic [31:0]        rdInstr;
  logic [AW:0]        count;
  logic               wrapped;
  logic               timeout;
  logic               frozen;
  logic               halt;

  modport master (
    output en, clr, pc, instr, rdIdx, rdEn,
    input  rdValid, rdCycle, rdPc, rdInstr, count, wrapped, timeout, frozen, halt
  );

  modport slave (
    input  en, clr, pc, instr, rdIdx, rdEn,
    output rdValid, rdCycle, rdPc, rdInstr, count, wrapped, timeout, frozen, halt
  );
endinterface

// File: rtl/sr_trace_monitor.sv
// sr_trace_monitor -- execution trace buffer and watchdog for schoolRISCV.
//
// Each enabled CPU step stores {cycle, pc, instr} into a circular buffer of
// DEPTH entries. A watchdog freezes capture after TIMEOUT steps (0 = off).
// A registered read port returns an entry by age (rdIdx 0 = oldest).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sr_trace_if.slave (capture inputs, read port, status flags)
//
// Optional feature: define SR_TRACE_STALL_DETECT_EN to freeze capture and
// raise halt after STALL_CYCLES consecutive captures of the same pc (the
// terminal "beq x0,x0,0" loop). Without it halt is constant 0.
module sr_trace_monitor #(
  parameter int DEPTH        = 16,
  parameter int CYCLE_W      = 16,
  parameter int TIMEOUT      = 120,
  parameter int STALL_CYCLES = 8
) (
  input logic       clk,
  input logic       rst_n,
  sr_trace_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Buffer RAM: no reset, an entry only becomes visible through r_count.
  logic [CYCLE_W+63:0] r_mem [DEPTH];

  logic [AW-1:0]      r_wr_ptr;
  logic [CYCLE_W-1:0] r_cycle;
  logic [AW:0]        r_count;
  logic               r_wrapped;
  logic               r_timeout;
  logic               r_frozen;
  logic               r_halt;
  logic               r_rd_valid;
  logic [CYCLE_W-1:0] r_rd_cycle;
  logic [31:0]        r_rd_pc;
  logic [31:0]        r_rd_instr;

  logic          w_cap;
  logic          w_wd_hit;
  logic          w_stall_hit;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_hit;

  // clr outranks a same-cycle capture; frozen blocks capture entirely.
  assign w_cap = bus.en & ~bus.clr & ~r_frozen;

  // Compared one bit wider than the counter so a saturated cycle value can
  // never alias onto a TIMEOUT larger than the counter range.
  assign w_wd_hit = (TIMEOUT != 0) &&
                    ((33'(r_cycle) + 33'd1) == 33'(TIMEOUT));

  // Oldest entry sits count slots behind the write pointer. When count==DEPTH
  // its low bits are 0, so the oldest entry is the one about to be overwritten.
  assign w_rd_addr = r_wr_ptr - r_count[AW-1:0] + bus.rdIdx;
  assign w_rd_hit  = ({1'b0, bus.rdIdx} < r_count);

`ifdef SR_TRACE_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES) + 1;

  logic [SW-1:0] r_stall_cnt;
  logic [31:0]   r_last_pc;
  logic          r_last_valid;
  logic          w_repeat;

  // r_stall_cnt counts repeats after the first capture of a pc, so it reaches
  // STALL_CYCLES-1 on the STALL_CYCLES-th identical capture.
  assign w_repeat    = r_last_valid & (bus.pc == r_last_pc);
  assign w_stall_hit = w_cap & w_repeat &
                       ((32'(r_stall_cnt) + 32'd1) == 32'(STALL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_last_pc    <= '0;
      r_last_valid <= 1'b0;
    end else if (bus.clr) begin
      r_stall_cnt  <= '0;
      r_last_pc    <= '0;
      r_last_valid <= 1'b0;
    end else if (w_cap) begin
      r_last_pc    <= bus.pc;
      r_last_valid <= 1'b1;
      r_stall_cnt  <= w_repeat ? r_stall_cnt + SW'(1) : '0;
    end
  end
`else
  assign w_stall_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_mem[r_wr_ptr] <= {r_cycle, bus.pc, bus.instr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_cycle   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_timeout <= 1'b0;
      r_frozen  <= 1'b0;
      r_halt    <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr  <= '0;
      r_cycle   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_timeout <= 1'b0;
      r_frozen  <= 1'b0;
      r_halt    <= 1'b0;
    end else if (w_cap) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_cycle != '1) begin
        r_cycle <= r_cycle + CYCLE_W'(1);
      end
      if (r_count == FULL) begin
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + (AW+1)'(1);
      end
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
        r_frozen  <= 1'b1;
      end
      if (w_stall_hit) begin
        r_halt   <= 1'b1;
        r_frozen <= 1'b1;
      end
    end
  end

  // Read port uses pre-edge pointer/count, so a same-edge capture is invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_cycle <= '0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
    end else if (bus.rdEn) begin
      r_rd_valid <= w_rd_hit;
      if (w_rd_hit) begin
        {r_rd_cycle, r_rd_pc, r_rd_instr} <= r_mem[w_rd_addr];
      end else begin
        r_rd_cycle <= '0;
        r_rd_pc    <= '0;
        r_rd_instr <= '0;
      end
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign bus.rdValid = r_rd_valid;
  assign bus.rdCycle = r_rd_cycle;
  assign bus.rdPc    = r_rd_pc;
  assign bus.rdInstr = r_rd_instr;
  assign bus.count   = r_count;
  assign bus.wrapped = r_wrapped;
  assign bus.timeout = r_timeout;
  assign bus.frozen  = r_frozen;
  assign bus.halt    = r_halt;
endmodule

// File: tb/tb_sr_trace_monitor.sv
// tb_sr_trace_monitor -- self-checking bench for sr_trace_monitor.
// Reference model: a queue of captured {cycle, pc, instr} records holding the
// newest DEPTH entries, plus flags computed from the capture rules.
module tb_sr_trace_monitor;
  localparam int DEPTH        = 16;
  localparam int CYCLE_W      = 16;
  localparam int TIMEOUT      = 120;
  localparam int STALL_CYCLES = 8;
  localparam int AW           = $clog2(DEPTH);
  localparam int EW           = CYCLE_W + 64;
  localparam int unsigned CYC_MAX = (1 << CYCLE_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_trace_if #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) bus ();

  sr_trace_monitor #(
    .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .TIMEOUT(TIMEOUT), .STALL_CYCLES(STALL_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0]      exp_q[$];
  int unsigned        m_cyc;
  logic               m_wrapped, m_timeout, m_frozen, m_halt;
  int                 m_run;
  logic [31:0]        m_last_pc;
  logic               m_rd_valid;
  logic [CYCLE_W-1:0] m_rd_cycle;
  logic [31:0]        m_rd_pc, m_rd_instr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cyc     = 0;
    m_wrapped = 1'b0;
    m_timeout = 1'b0;
    m_frozen  = 1'b0;
    m_halt    = 1'b0;
    m_run     = 0;
    m_last_pc = '0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},   64'(bus.count),   64'(exp_q.size()));
    check({tag, ".wrapped"}, 64'(bus.wrapped), 64'(m_wrapped));
    check({tag, ".timeout"}, 64'(bus.timeout), 64'(m_timeout));
    check({tag, ".frozen"},  64'(bus.frozen),  64'(m_frozen));
    check({tag, ".halt"},    64'(bus.halt),    64'(m_halt));
    check({tag, ".rdValid"}, 64'(bus.rdValid), 64'(m_rd_valid));
    check({tag, ".rdCycle"}, 64'(bus.rdCycle), 64'(m_rd_cycle));
    check({tag, ".rdPc"},    64'(bus.rdPc),    64'(m_rd_pc));
    check({tag, ".rdInstr"}, 64'(bus.rdInstr), 64'(m_rd_instr));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic clr, input logic [31:0] pc,
                      input logic [31:0] instr, input logic rd_en, input int rd_idx);
    bus.en    = en;
    bus.clr   = clr;
    bus.pc    = pc;
    bus.instr = instr;
    bus.rdEn  = rd_en;
    bus.rdIdx = AW'(rd_idx);
    // read sees the buffer as it stood before this edge
    if (rd_en) begin
      if (rd_idx < exp_q.size()) begin
        {m_rd_cycle, m_rd_pc, m_rd_instr} = exp_q[rd_idx];
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
        m_rd_cycle = '0;
        m_rd_pc    = '0;
        m_rd_instr = '0;
      end
    end else begin
      m_rd_valid = 1'b0;
    end
    if (clr) begin
      model_clear();
    end else if (en && !m_frozen) begin
      exp_q.push_back({CYCLE_W'(m_cyc), pc, instr});
      if (exp_q.size() > DEPTH) begin
        void'(exp_q.pop_front());
        m_wrapped = 1'b1;
      end
      m_run     = (m_run > 0 && pc == m_last_pc) ? m_run + 1 : 1;
      m_last_pc = pc;
      if (TIMEOUT != 0 && m_cyc + 1 == TIMEOUT) begin
        m_timeout = 1'b1;
        m_frozen  = 1'b1;
      end
`ifdef SR_TRACE_STALL_DETECT_EN
      if (m_run >= STALL_CYCLES) begin
        m_halt   = 1'b1;
        m_frozen = 1'b1;
      end
`endif
      if (m_cyc < CYC_MAX) m_cyc++;
    end
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    bus.en    = 1'b0;
    bus.clr   = 1'b0;
    bus.pc    = '0;
    bus.instr = '0;
    bus.rdEn  = 1'b0;
    bus.rdIdx = '0;
    rst_n     = 1'b0;
    model_clear();
    m_rd_valid = 1'b0;
    m_rd_cycle = '0;
    m_rd_pc    = '0;
    m_rd_instr = '0;
    #3;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic        rd_en;
    int          rd_idx;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
    int          exp_cycle;
  } vec_t;

  function automatic vec_t mk(logic en, logic [31:0] pc, logic rd_en, int rd_idx,
                              int ec, logic ev, logic [31:0] ep, int ecy);
    vec_t v;
    v.en = en; v.pc = pc; v.rd_en = rd_en; v.rd_idx = rd_idx;
    v.exp_count = ec; v.exp_valid = ev; v.exp_pc = ep; v.exp_cycle = ecy;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1, 32'd0,   0, 0, 1, 0, 32'd0,   0);
    tbl[1]  = mk(1, 32'd4,   0, 0, 2, 0, 32'd0,   0);
    tbl[2]  = mk(1, 32'd8,   0, 0, 3, 0, 32'd0,   0);
    tbl[3]  = mk(1, 32'd12,  0, 0, 4, 0, 32'd0,   0);
    tbl[4]  = mk(1, 32'd16,  0, 0, 5, 0, 32'd0,   0);
    tbl[5]  = mk(0, 32'd0,   1, 0, 5, 1, 32'd0,   0);
    tbl[6]  = mk(0, 32'd0,   1, 4, 5, 1, 32'd16,  4);
    tbl[7]  = mk(0, 32'd0,   1, 5, 5, 0, 32'd0,   0);
    tbl[8]  = mk(0, 32'd0,   1, 2, 5, 1, 32'd8,   2);
    tbl[9]  = mk(0, 32'd0,   0, 2, 5, 0, 32'd8,   2);
    tbl[10] = mk(1, 32'd100, 1, 5, 6, 0, 32'd0,   0);
    tbl[11] = mk(0, 32'd0,   1, 5, 6, 1, 32'd100, 5);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, 1'b0, tbl[i].pc, tbl[i].pc + 32'h13, tbl[i].rd_en, tbl[i].rd_idx);
      check($sformatf("tbl[%0d].count", i),   64'(bus.count),   64'(tbl[i].exp_count));
      check($sformatf("tbl[%0d].rdValid", i), 64'(bus.rdValid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl[%0d].rdPc", i),    64'(bus.rdPc),    64'(tbl[i].exp_pc));
      check($sformatf("tbl[%0d].rdCycle", i), 64'(bus.rdCycle), 64'(tbl[i].exp_cycle));
    end

    // wrap: 20 captures into 16 entries
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 32'(4 * k), 32'h13 + 32'(k), 1'b0, 0);
    check("wrap.count", 64'(bus.count), 64'd16);
    check("wrap.wrapped", 64'(bus.wrapped), 64'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 0);
    check("wrap.idx0.pc", 64'(bus.rdPc), 64'd16);
    check("wrap.idx0.cycle", 64'(bus.rdCycle), 64'd4);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 15);
    check("wrap.idx15.pc", 64'(bus.rdPc), 64'd76);
    check("wrap.idx15.cycle", 64'(bus.rdCycle), 64'd19);

    // watchdog: en held for 200 cycles
    do_reset();
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b0, 32'(4 * k), 32'h33 + 32'(k), 1'b0, 0);
      if (k == 118) check("wd.before", 64'(bus.timeout), 64'd0);
      if (k == 119) begin
        check("wd.timeout", 64'(bus.timeout), 64'd1);
        check("wd.frozen", 64'(bus.frozen), 64'd1);
      end
    end
    check("wd.count", 64'(bus.count), 64'd16);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 15);
    check("wd.last.cycle", 64'(bus.rdCycle), 64'd119);
    check("wd.last.pc", 64'(bus.rdPc), 64'd476);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 0);
    check("wd.first.cycle", 64'(bus.rdCycle), 64'd104);

    // clr from frozen state, then clr colliding with en after 50 captures
    step(1'b1, 1'b1, 32'h77, 32'h77, 1'b0, 0);
    check("clr.frozen", 64'(bus.frozen), 64'd0);
    check("clr.timeout", 64'(bus.timeout), 64'd0);
    check("clr.wrapped", 64'(bus.wrapped), 64'd0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 32'(8 * k), 32'(k), 1'b0, 0);
    step(1'b1, 1'b1, 32'h555, 32'h555, 1'b0, 0);
    check("clr.count", 64'(bus.count), 64'd0);
    step(1'b1, 1'b0, 32'h300, 32'h13, 1'b0, 0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 0);
    check("clr.next.cycle", 64'(bus.rdCycle), 64'd0);
    check("clr.next.pc", 64'(bus.rdPc), 64'h300);
    check("clr.next.count", 64'(bus.count), 64'd1);

    // idle cycles are not counted
    do_reset();
    step(1'b1, 1'b0, 32'd0,  32'h13, 1'b0, 0);
    step(1'b0, 1'b0, 32'h99, 32'h0,  1'b0, 0);
    step(1'b0, 1'b0, 32'h99, 32'h0,  1'b0, 0);
    step(1'b1, 1'b0, 32'd4,  32'h13, 1'b0, 0);
    check("idle.count", 64'(bus.count), 64'd2);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 0);
    check("idle.idx0.cycle", 64'(bus.rdCycle), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1);
    check("idle.idx1.cycle", 64'(bus.rdCycle), 64'd1);
    check("idle.idx1.pc", 64'(bus.rdPc), 64'd4);

    // stall detection (halt stays 0 without the feature)
    do_reset();
    for (int k = 0; k < STALL_CYCLES; k++) begin
      step(1'b1, 1'b0, 32'h20, 32'h0000_0063, 1'b0, 0);
`ifdef SR_TRACE_STALL_DETECT_EN
      if (k == STALL_CYCLES - 2) check("stall.early", 64'(bus.halt), 64'd0);
      if (k == STALL_CYCLES - 1) begin
        check("stall.halt", 64'(bus.halt), 64'd1);
        check("stall.frozen", 64'(bus.frozen), 64'd1);
      end
`endif
    end
`ifndef SR_TRACE_STALL_DETECT_EN
    check("nostall.halt", 64'(bus.halt), 64'd0);
    check("nostall.frozen", 64'(bus.frozen), 64'd0);
`endif
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 0);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b0, (k % 2 == 0) ? 32'h20 : 32'h24, 32'h63, 1'b0, 0);
    end
    check("alt.halt", 64'(bus.halt), 64'd0);
    check("alt.count", 64'(bus.count), 64'd16);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
           32'(4 * $urandom_range(0, 3)), $urandom,
           1'(($urandom_range(0, 1))), $urandom_range(0, DEPTH - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
